dec2hex_conv: RTL

Sequential BCD-to-binary converter. It takes a 4-digit packed BCD word (0000..9999) and produces the equivalent 16-bit binary value using a reverse double-dabble algorithm: shift right, then subtract 3 from any digit that is 8 or more. It is the inverse of the display-side binary-to-BCD path, for user or keypad decimal entry feeding binary datapaths. It runs on the system clk, gated by the CE chain used throughout the codebase.

---
 rtl/dec2hex_conv.sv | 117 +++++++++++
 1 files changed

// File: rtl/dec2hex_conv.sv
// rtl/dec2hex_conv.sv - sequential packed-BCD to binary converter (reverse double-dabble)
// Validates the digits, then runs 16 shift-right/subtract-3 steps and registers the binary result.
module dec2hex_conv #(
  parameter int NDIG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CE,
  input  logic        start,
  input  logic [15:0] I,
  output logic [15:0] O,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int BW = NDIG * 4;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2*BW-1:0] sr_q, sr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [BW-1:0]   o_q, o_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            bad_digit;

  // Shift the whole register right, then pull each BCD digit that reached 8+ back by 3.
  function automatic logic [2*BW-1:0] adj_shift(input logic [2*BW-1:0] sr);
    logic [2*BW-1:0] s;
    s = sr >> 1;
    for (int i = 0; i < NDIG; i++) begin
      if (s[BW+4*i +: 4] >= 4'd8) s[BW+4*i +: 4] = s[BW+4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (sr_q[BW+4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (CE) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sr_d    = {I, {BW{1'b0}}};
            cnt_d   = 4'd0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (bad_digit) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr_d  = adj_shift(sr_q);
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_DONE;
        end
        S_DONE: begin
          o_d     = sr_q[BW-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign O    = o_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
